// File: rtl/gcm_pkg.sv
// Shared GCM definitions: FSM state type, block/length widths and the byte-mask helper.
package gcm_pkg;
  localparam int GCM_BLK_W = 128;
  localparam int GCM_LEN_W = 64;
  localparam int GCM_BYTES = GCM_BLK_W / 8;

  typedef logic [2:0] state_e;
  localparam state_e S_IDLE = 3'd0;
  localparam state_e S_DATA = 3'd1;
  localparam state_e S_LEN  = 3'd2;
  localparam state_e S_WAIT = 3'd3;
  localparam state_e S_TAG  = 3'd4;

  // keep[b] guards data[8b+7:8b], so keep[15] covers byte 0 (the MSB byte).
  function automatic logic [GCM_BLK_W-1:0] mask_bytes(input logic [GCM_BLK_W-1:0] data,
                                                      input logic [GCM_BYTES-1:0] keep);
    logic [GCM_BLK_W-1:0] m;
    m = '0;
    for (int b = 0; b < GCM_BYTES; b++) m[8*b +: 8] = data[8*b +: 8] & {8{keep[b]}};
    return m;
  endfunction
endpackage

// File: rtl/gcm_len_cnt.sv
// len(A)/len(C) bit counters; outputs are the post-update values so a length
// block can be formed in the same cycle as the final beat.
module gcm_len_cnt
  import gcm_pkg::*;
(
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 i_clr,
  input  logic                 i_add,
  input  logic                 i_type,
  input  logic [GCM_BYTES-1:0] i_keep,
  output logic [GCM_LEN_W-1:0] o_len_a_nxt,
  output logic [GCM_LEN_W-1:0] o_len_c_nxt
);
  logic [GCM_LEN_W-1:0] r_len_a, r_len_c;
  logic [GCM_LEN_W-1:0] w_base_a, w_base_c, w_bits;
  logic [4:0]           w_pop;

  always_comb begin
    w_pop = '0;
    for (int b = 0; b < GCM_BYTES; b++) w_pop = w_pop + 5'(i_keep[b]);
  end

  assign w_bits      = {{(GCM_LEN_W-8){1'b0}}, w_pop, 3'b000};
  assign w_base_a    = i_clr ? '0 : r_len_a;
  assign w_base_c    = i_clr ? '0 : r_len_c;
  assign o_len_a_nxt = w_base_a + ((i_add && !i_type) ? w_bits : '0);
  assign o_len_c_nxt = w_base_c + ((i_add &&  i_type) ? w_bits : '0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_len_a <= '0;
      r_len_c <= '0;
    end else begin
      r_len_a <= o_len_a_nxt;
      r_len_c <= o_len_c_nxt;
    end
  end
endmodule

// File: rtl/gcm_ghash_feeder.sv
// GHASH producer: pads AAD/CT beats, appends len(A)||len(C), forms tag = GHASH ^ E(K,J0).
// Build option GCM_TAG_CHECK_EN: compare against tag_exp_i and keep tag_o at zero.
module gcm_ghash_feeder
  import gcm_pkg::*;
(
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [GCM_BLK_W-1:0] data_i,
  input  logic [GCM_BYTES-1:0] keep_i,
  input  logic                 type_i,
  input  logic                 last_i,
  input  logic                 valid_i,
  output logic                 ready_o,
  output logic [GCM_BLK_W-1:0] ghash_din_o,
  output logic                 ghash_din_valid_o,
  input  logic                 ghash_din_ready_i,
  output logic                 ghash_last_o,
  input  logic [GCM_BLK_W-1:0] ghash_dout_i,
  input  logic                 ghash_dout_valid_i,
  input  logic [GCM_BLK_W-1:0] ekj0_i,
  input  logic                 ekj0_valid_i,
`ifdef GCM_TAG_CHECK_EN
  input  logic [GCM_BLK_W-1:0] tag_exp_i,
  output logic                 tag_match_o,
`endif
  output logic [GCM_BLK_W-1:0] tag_o,
  output logic                 tag_valid_o,
  output logic                 err_o
);
  state_e               r_state;
  logic [GCM_BLK_W-1:0] r_din, r_hash, r_ekj0;
  logic                 r_din_vld, r_last, r_hash_vld, r_ekj0_vld, r_err, r_seen_ct;
  logic                 w_start, w_acc, w_drop, w_emit, w_xfer, w_len_load, w_seen_ct;
  logic [GCM_LEN_W-1:0] w_len_a, w_len_c;
  logic [GCM_BLK_W-1:0] w_tag;

  // The first beat is taken in IDLE so a message starts with no bubble.
  assign w_start    = (r_state == S_IDLE) & valid_i;
  assign ready_o    = ((r_state == S_DATA) | w_start) & (!r_din_vld | ghash_din_ready_i);
  assign w_acc      = valid_i & ready_o;
  assign w_xfer     = r_din_vld & ghash_din_ready_i;
  assign w_seen_ct  = w_start ? 1'b0 : r_seen_ct;
  assign w_drop     = w_acc & !type_i & w_seen_ct;
  assign w_emit     = w_acc & !w_drop & (keep_i != '0);
  // A final beat with nothing to emit loads the length block directly.
  assign w_len_load = (w_acc & last_i) | ((r_state == S_LEN) & !r_last & (!r_din_vld | w_xfer));

  gcm_len_cnt u_len (
    .clk        (clk),
    .rst_n      (rst_n),
    .i_clr      (w_start),
    .i_add      (w_acc & !w_drop),
    .i_type     (type_i),
    .i_keep     (keep_i),
    .o_len_a_nxt(w_len_a),
    .o_len_c_nxt(w_len_c)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_IDLE;
    else begin
      case (r_state)
        S_IDLE:  if (valid_i) r_state <= last_i ? S_LEN : S_DATA;
        S_DATA:  if (w_acc && last_i) r_state <= S_LEN;
        S_LEN:   if (w_xfer && r_last) r_state <= S_WAIT;
        S_WAIT:  if (r_hash_vld && r_ekj0_vld) r_state <= S_TAG;
        S_TAG:   r_state <= S_IDLE;
        default: r_state <= S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_din     <= '0;
      r_din_vld <= 1'b0;
      r_last    <= 1'b0;
    end else if (w_emit) begin
      r_din     <= mask_bytes(data_i, keep_i);
      r_din_vld <= 1'b1;
      r_last    <= 1'b0;
    end else if (w_len_load) begin
      r_din     <= {w_len_a, w_len_c};
      r_din_vld <= 1'b1;
      r_last    <= 1'b1;
    end else if (w_xfer) begin
      r_din_vld <= 1'b0;
      r_last    <= 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_err     <= 1'b0;
      r_seen_ct <= 1'b0;
    end else begin
      if (w_drop)       r_err <= 1'b1;
      else if (w_start) r_err <= 1'b0;
      if (w_acc && !w_drop && type_i) r_seen_ct <= 1'b1;
      else if (w_start)               r_seen_ct <= 1'b0;
    end
  end

  // An ekj0 strobe during S_TAG survives the flag clear and serves the next message.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_hash     <= '0;
      r_hash_vld <= 1'b0;
      r_ekj0     <= '0;
      r_ekj0_vld <= 1'b0;
    end else begin
      if (r_state == S_TAG) r_hash_vld <= 1'b0;
      else if (ghash_dout_valid_i) begin
        r_hash     <= ghash_dout_i;
        r_hash_vld <= 1'b1;
      end
      if (ekj0_valid_i) begin
        r_ekj0     <= ekj0_i;
        r_ekj0_vld <= 1'b1;
      end else if (r_state == S_TAG) r_ekj0_vld <= 1'b0;
    end
  end

  assign ghash_din_o       = r_din;
  assign ghash_din_valid_o = r_din_vld;
  assign ghash_last_o      = r_last;
  assign err_o             = r_err;
  assign tag_valid_o       = (r_state == S_TAG);
  assign w_tag             = r_hash ^ r_ekj0;
`ifdef GCM_TAG_CHECK_EN
  assign tag_o       = '0;
  assign tag_match_o = tag_valid_o & (w_tag == tag_exp_i);
`else
  assign tag_o       = tag_valid_o ? w_tag : '0;
`endif
endmodule
